// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-SRAM load/store unit.
//   SIZE_*     : encodings of the request size field
//   DMEM_BASE  : default byte base of the SRAM window
//   state_e    : LSU control state encoding
//   align_lane : forces a byte offset onto the natural boundary of an access
//   misaligned : flags an offset that is off the natural boundary of an access
package dmem_lsu_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    localparam logic [31:0] DMEM_BASE = 32'h1000_0000;

    // ISSUE : store write cycle (mem_we high)
    // WAIT  : load address presented, SRAM read in flight
    // CAP   : SRAM read data valid, extracted into the response register
    // RESP  : response held until the consumer takes it
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAP   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
        logic [1:0] res;
        case (size)
            SIZE_H:  res = {lane[1], 1'b0};
            SIZE_W:  res = 2'b00;
            default: res = lane;
        endcase
        return res;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic res;
        case (size)
            SIZE_H:  res = lane[0];
            SIZE_W:  res = (lane != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational byte-lane steering for the data-SRAM LSU.
// Store side: replicates right-justified store data across the word and
//   builds the byte strobes for the addressed lane(s).
// Load side: picks the addressed byte/half out of the SRAM word and
//   sign- or zero-extends it.
// Ports:
//   st_size_i/st_lane_i/st_wdata_i -> st_wdata_o/st_wstrb_o
//   ld_size_i/ld_lane_i/ld_unsigned_i/ld_rdata_i -> ld_data_o
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_lane_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    assign ld_byte_s = (ld_lane_i == 2'd0) ? ld_rdata_i[7:0]   :
                       (ld_lane_i == 2'd1) ? ld_rdata_i[15:8]  :
                       (ld_lane_i == 2'd2) ? ld_rdata_i[23:16] :
                                             ld_rdata_i[31:24];
    assign ld_half_s = ld_lane_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

    // Store data replication and byte-strobe generation
    always_comb begin
        st_wdata_o = 32'h0000_0000;
        st_wstrb_o = 4'b0000;
        case (st_size_i)
            SIZE_B: begin
                st_wdata_o = {4{st_wdata_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_lane_i;
            end
            SIZE_H: begin
                st_wdata_o = {2{st_wdata_i[15:0]}};
                st_wstrb_o = st_lane_i[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_W: begin
                st_wdata_o = st_wdata_i;
                st_wstrb_o = 4'b1111;
            end
            default: begin
                st_wdata_o = 32'h0000_0000;
                st_wstrb_o = 4'b0000;
            end
        endcase
    end

    // Load lane extraction with sign/zero extension
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (ld_size_i)
            SIZE_B:  ld_data_o = ld_unsigned_i ? {24'h00_0000, ld_byte_s}
                                               : {{24{ld_byte_s[7]}}, ld_byte_s};
            SIZE_H:  ld_data_o = ld_unsigned_i ? {16'h0000, ld_half_s}
                                               : {{16{ld_half_s[15]}}, ld_half_s};
            SIZE_W:  ld_data_o = ld_rdata_i;
            default: ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the data SRAM window [BASE_ADDR, BASE_ADDR + (4<<ADDR_W) - 1].
// One request per handshake; range/size faults answer without touching the SRAM.
// Loads absorb the SRAM's one-cycle synchronous read; all outputs are registered.
// Build option: define DMEM_LSU_MISALIGN_TRAP_EN to fault misaligned half/word
//   accesses; otherwise their low address bits are cleared and the access proceeds.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_*_i / req_ready_o         CPU request channel
//   rsp_*_o / rsp_ready_i         CPU response channel (held until taken)
//   mem_we_o/addr_o/wdata_o/wstrb_o, mem_rdata_i   SRAM port
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DMEM_BASE,
    parameter int          ADDR_W    = 14
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_W;

    state_e            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              uns_q, uns_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

    logic [31:0]       offset_s;
    logic              in_range_s;
    logic [1:0]        lane_s;
    logic              fault_s;
    logic              accept_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [31:0]       st_wdata_s;
    logic [3:0]        st_wstrb_s;
    logic [31:0]       ld_data_s;

    // An address below the base wraps to a huge offset, so one compare covers both ends.
    assign offset_s    = req_addr_i - BASE_ADDR;
    assign in_range_s  = (offset_s < WIN_BYTES);
    assign word_addr_s = offset_s[ADDR_W+1:2];
    assign accept_s    = req_valid_i && (state_q == ST_IDLE);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    assign lane_s  = req_addr_i[1:0];
    assign fault_s = !in_range_s || (req_size_i == SIZE_RSV) ||
                     misaligned(req_size_i, req_addr_i[1:0]);
`else
    assign lane_s  = align_lane(req_size_i, req_addr_i[1:0]);
    assign fault_s = !in_range_s || (req_size_i == SIZE_RSV);
`endif

    dmem_lsu_align u_align (
        .st_size_i     (req_size_i),
        .st_lane_i     (lane_s),
        .st_wdata_i    (req_wdata_i),
        .st_wdata_o    (st_wdata_s),
        .st_wstrb_o    (st_wstrb_s),
        .ld_size_i     (size_q),
        .ld_lane_i     (lane_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (mem_rdata_i),
        .ld_data_o     (ld_data_s)
    );

    // Control state transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (fault_s) begin
                        state_d = ST_RESP;
                    end else if (req_we_i) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_WAIT:  state_d = ST_CAP;
            ST_CAP:   state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request latching, SRAM port drive and response capture
    always_comb begin
        size_d      = size_q;
        lane_d      = lane_q;
        uns_d       = uns_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_we_d    = 1'b0;
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        if (accept_s) begin
            size_d      = req_size_i;
            lane_d      = lane_s;
            uns_d       = req_unsigned_i;
            rsp_err_d   = fault_s;
            rsp_rdata_d = 32'h0000_0000;
            // A faulting request leaves the SRAM port untouched.
            if (!fault_s) begin
                mem_addr_d = word_addr_s;
            end else begin
                mem_addr_d = mem_addr_q;
            end
            if (!fault_s && req_we_i) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = st_wdata_s;
                mem_wstrb_d = st_wstrb_s;
            end else begin
                mem_we_d    = 1'b0;
            end
        end else if (state_q == ST_CAP) begin
            rsp_rdata_d = ld_data_s;
        end else if ((state_q == ST_RESP) && rsp_ready_i) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0000_0000;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            uns_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            uns_q       <= uns_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed, table-driven bench for dmem_lsu with a behavioural synchronous SRAM.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    dmem_lsu #(.BASE_ADDR(32'h1000_0000), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: byte-masked write, read data one cycle after the address
    logic [31:0] sram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= sram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [13:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [0:31];
    int   nv = 0;

    task automatic add(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                       input logic [13:0] maddr, input logic [3:0] wstrb,
                       input logic [31:0] mwdata, input logic [31:0] rdata);
        vt[nv] = '{we, size, uns, addr, wdata, err, maddr, wstrb, mwdata, rdata};
        nv++;
    endtask

    // Drive one request, then watch up to 8 cycles for the SRAM port and the response.
    task automatic run(input int idx);
        vec_t v;
        int   lat;
        int   we_cnt;
        int   exp_lat;
        bit   got;
        v = vt[idx];
        exp_lat = v.err ? 1 : (v.we ? 2 : 3);
        @(negedge clk);
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0; we_cnt = 0; got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (k == 1 && !v.err) chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.maddr));
            if (mem_we) begin
                we_cnt++;
                chk($sformatf("v%0d wstrb", idx), 32'(mem_wstrb), 32'(v.wstrb));
                chk($sformatf("v%0d wdata", idx), mem_wdata, v.mwdata);
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat));
        chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.err));
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.rdata);
        chk($sformatf("v%0d we_cycles", idx), 32'(we_cnt), (v.we && !v.err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        //  we    size    uns   addr          wdata         err   maddr     wstrb    mwdata        rdata
        add(1'b1, SIZE_W, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0, 14'd4,    4'b1111, 32'hDEAD_BEEF, 32'h0);
        add(1'b0, SIZE_W, 1'b0, 32'h1000_0010, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'hDEAD_BEEF);
        add(1'b1, SIZE_B, 1'b0, 32'h1000_0013, 32'h1234_5680, 1'b0, 14'd4,    4'b1000, 32'h8080_8080, 32'h0);
        add(1'b0, SIZE_B, 1'b0, 32'h1000_0013, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'hFFFF_FF80);
        add(1'b0, SIZE_B, 1'b1, 32'h1000_0013, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'h0000_0080);
        add(1'b0, SIZE_W, 1'b0, 32'h1000_0010, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'h80AD_BEEF);
        add(1'b1, SIZE_W, 1'b0, 32'h1000_0010, 32'h8001_7FFF, 1'b0, 14'd4,    4'b1111, 32'h8001_7FFF, 32'h0);
        add(1'b0, SIZE_H, 1'b0, 32'h1000_0012, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'hFFFF_8001);
        add(1'b0, SIZE_H, 1'b0, 32'h1000_0010, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'h0000_7FFF);
        add(1'b0, SIZE_H, 1'b1, 32'h1000_0012, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'h0000_8001);
        add(1'b0, SIZE_W, 1'b0, 32'h0FFF_FFFC, 32'h0,         1'b1, 14'd0,    4'b0000, 32'h0,         32'h0);
        add(1'b1, SIZE_W, 1'b0, 32'h1001_0000, 32'h5555_5555, 1'b1, 14'd0,    4'b0000, 32'h0,         32'h0);
        add(1'b0, SIZE_RSV,1'b0,32'h1000_0010, 32'h0,         1'b1, 14'd0,    4'b0000, 32'h0,         32'h0);
        add(1'b1, SIZE_B, 1'b0, 32'h1000_FFFF, 32'h0000_00A5, 1'b0, 14'h3FFF, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        add(1'b0, SIZE_B, 1'b0, 32'h1000_FFFF, 32'h0,         1'b0, 14'h3FFF, 4'b0000, 32'h0,         32'hFFFF_FFA5);
        add(1'b1, SIZE_W, 1'b0, 32'h1000_0014, 32'h0000_0000, 1'b0, 14'd5,    4'b1111, 32'h0000_0000, 32'h0);
        add(1'b1, SIZE_H, 1'b0, 32'h1000_0016, 32'h1234_BEEF, 1'b0, 14'd5,    4'b1100, 32'hBEEF_BEEF, 32'h0);
        add(1'b0, SIZE_W, 1'b0, 32'h1000_0014, 32'h0,         1'b0, 14'd5,    4'b0000, 32'h0,         32'hBEEF_0000);
        add(1'b0, SIZE_B, 1'b1, 32'h1000_0017, 32'h0,         1'b0, 14'd5,    4'b0000, 32'h0,         32'h0000_00BE);
        add(1'b1, SIZE_W, 1'b0, 32'h1000_0000, 32'hCAFE_F00D, 1'b0, 14'd0,    4'b1111, 32'hCAFE_F00D, 32'h0);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        add(1'b1, SIZE_W, 1'b0, 32'h1000_0002, 32'h1122_3344, 1'b1, 14'd0,    4'b0000, 32'h0,         32'h0);
        add(1'b0, SIZE_W, 1'b0, 32'h1000_0000, 32'h0,         1'b0, 14'd0,    4'b0000, 32'h0,         32'hCAFE_F00D);
        add(1'b0, SIZE_H, 1'b1, 32'h1000_0001, 32'h0,         1'b1, 14'd0,    4'b0000, 32'h0,         32'h0);
`else
        add(1'b1, SIZE_W, 1'b0, 32'h1000_0002, 32'h1122_3344, 1'b0, 14'd0,    4'b1111, 32'h1122_3344, 32'h0);
        add(1'b0, SIZE_W, 1'b0, 32'h1000_0000, 32'h0,         1'b0, 14'd0,    4'b0000, 32'h0,         32'h1122_3344);
        add(1'b0, SIZE_H, 1'b1, 32'h1000_0001, 32'h0,         1'b0, 14'd0,    4'b0000, 32'h0,         32'h0000_3344);
`endif
        // Last entry is replayed after the mid-operation reset.
        add(1'b0, SIZE_W, 1'b0, 32'h1000_0010, 32'h0,         1'b0, 14'd4,    4'b0000, 32'h0,         32'h8001_7FFF);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_err",   32'(rsp_err),   32'd0);
        chk("rst rsp_rdata", rsp_rdata,      32'd0);
        chk("rst mem_we",    32'(mem_we),    32'd0);
        chk("rst mem_addr",  32'(mem_addr),  32'd0);
        chk("rst mem_wdata", mem_wdata,      32'd0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < nv - 1; i++) run(i);

        // Back-pressure: response must hold and no new request may slip in
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_W; req_addr = 32'h1000_0010;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp first rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp first rdata", rsp_rdata, 32'h8001_7FFF);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1000_0020; req_wdata = 32'h5555_5555;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("bp%0d rsp_valid", s), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rdata", s), rsp_rdata, 32'h8001_7FFF);
            chk($sformatf("bp%0d req_ready", s), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d mem_we", s), 32'(mem_we), 32'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp after rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp after req_ready", 32'(req_ready), 32'd1);
        chk("bp after mem_we", 32'(mem_we), 32'd0);

        // Asynchronous reset while the store is in its write cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_W;
        req_addr = 32'h1000_0030; req_wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rsti issue mem_we", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rsti mem_we", 32'(mem_we), 32'd0);
        chk("rsti req_ready", 32'(req_ready), 32'd1);
        chk("rsti rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rsti%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
            chk($sformatf("rsti%0d mem_we", c), 32'(mem_we), 32'd0);
        end
        run(nv - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
